// File: rtl/mapped_memory_slave_if.sv
// Core-side memory port: request signals from the core, response/stall from the memory model.
interface mapped_memory_slave_if #(
    parameter int BITS = 32
);
    logic              cen;
    logic              wen;
    logic [BITS/8-1:0] be;
    logic [31:0]       a;
    logic [BITS-1:0]   d;
    logic [BITS-1:0]   q;
    logic              stall;
    logic              err;

    modport master (output cen, wen, be, a, d, input q, stall, err);
    modport slave  (input cen, wen, be, a, d, output q, stall, err);
endinterface

// File: rtl/mapped_memory_slave.sv
// Behavioural word memory with base-address decode, byte-lane writes and a
// fixed number of wait cycles per access, signalled to the core through stall.
module mapped_memory_slave #(
    parameter int          BITS       = 32,
    parameter int          WORD_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          LATENCY    = 2
) (
    input logic                  clk,
    input logic                  rst,
    mapped_memory_slave_if.slave bus
);
    localparam int BYTES = BITS / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IW    = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                           state_q, state_d;
    logic [3:0]                       cnt_q, cnt_d;
    logic                             hit_q, hit_d;
    logic                             wen_q, wen_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [BYTES-1:0]                 be_q, be_d;
    logic [BITS-1:0]                  dat_q, dat_d;
    logic [BITS-1:0]                  q_q, q_d;
    logic                             err_q, err_d;
    logic [WORD_DEPTH-1:0][BITS-1:0]  mem_q, mem_d;

    logic [31:0]      off;
    logic             in_hit;
    logic [IW-1:0]    in_idx;
    logic             acc_hit, acc_wen, fire;
    logic [IW-1:0]    acc_idx;
    logic [BYTES-1:0] acc_be;
    logic [BITS-1:0]  acc_d;

    always_comb begin
        off    = bus.a - BASE_ADDR;
        in_hit = (bus.a >= BASE_ADDR) && ((off >> LSB) < 32'(WORD_DEPTH))
                 && ((off & 32'(BYTES - 1)) == 32'd0);
        in_idx = IW'(off >> LSB);
    end

    // With LATENCY==1 the access completes straight out of IDLE, so the
    // commit/readout must use the live inputs rather than the latched copy.
    always_comb begin
        acc_hit = (state_q == IDLE) ? in_hit  : hit_q;
        acc_wen = (state_q == IDLE) ? bus.wen : wen_q;
        acc_idx = (state_q == IDLE) ? in_idx  : idx_q;
        acc_be  = (state_q == IDLE) ? bus.be  : be_q;
        acc_d   = (state_q == IDLE) ? bus.d   : dat_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        wen_d   = wen_q;
        idx_d   = idx_q;
        be_d    = be_q;
        dat_d   = dat_q;
        mem_d   = mem_q;
        q_d     = '0;
        err_d   = 1'b0;
        fire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cen) begin
                    hit_d = in_hit;
                    wen_d = bus.wen;
                    idx_d = in_idx;
                    be_d  = bus.be;
                    dat_d = bus.d;
                    cnt_d = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fire) begin
            err_d = ~acc_hit;
            if (acc_hit) begin
                if (acc_wen) begin
                    for (int k = 0; k < BYTES; k++)
                        if (acc_be[k]) mem_d[acc_idx][8*k +: 8] = acc_d[8*k +: 8];
                end else begin
                    q_d = mem_q[acc_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            wen_q   <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            dat_q   <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            wen_q   <= wen_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            dat_q   <= dat_d;
            q_q     <= q_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    // rst gates stall so a held cen cannot keep the core frozen during reset.
    assign bus.stall = ~rst & (((state_q == IDLE) & bus.cen) | (state_q == WAIT));
    assign bus.q     = q_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_mapped_memory_slave.sv
// Directed bench: three memories (latency 2, 1, 4) sharing one stimulus bus, selected by sel.
module tb_mapped_memory_slave;
    localparam logic [31:0] BASE = 32'h100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        cen_t = 1'b0, wen_t = 1'b0;
    logic [3:0]  be_t  = '0;
    logic [31:0] a_t   = '0, d_t = '0;
    logic [1:0]  sel   = 2'd0;
    logic [31:0] q_o;
    logic        stall_o, err_o;

    int total = 0;
    int bad   = 0;

    mapped_memory_slave_if #(.BITS(32)) if2 ();
    mapped_memory_slave_if #(.BITS(32)) if1 ();
    mapped_memory_slave_if #(.BITS(32)) if4 ();

    assign if2.cen = cen_t & (sel == 2'd0);
    assign if1.cen = cen_t & (sel == 2'd1);
    assign if4.cen = cen_t & (sel == 2'd2);
    assign if2.wen = wen_t;  assign if1.wen = wen_t;  assign if4.wen = wen_t;
    assign if2.be  = be_t;   assign if1.be  = be_t;   assign if4.be  = be_t;
    assign if2.a   = a_t;    assign if1.a   = a_t;    assign if4.a   = a_t;
    assign if2.d   = d_t;    assign if1.d   = d_t;    assign if4.d   = d_t;

    always_comb begin
        case (sel)
            2'd1:    begin q_o = if1.q; stall_o = if1.stall; err_o = if1.err; end
            2'd2:    begin q_o = if4.q; stall_o = if4.stall; err_o = if4.err; end
            default: begin q_o = if2.q; stall_o = if2.stall; err_o = if2.err; end
        endcase
    end

    mapped_memory_slave #(.BITS(32), .WORD_DEPTH(32), .BASE_ADDR(BASE), .LATENCY(2))
        u_l2 (.clk(clk), .rst(rst), .bus(if2.slave));
    mapped_memory_slave #(.BITS(32), .WORD_DEPTH(32), .BASE_ADDR(BASE), .LATENCY(1))
        u_l1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mapped_memory_slave #(.BITS(32), .WORD_DEPTH(32), .BASE_ADDR(BASE), .LATENCY(4))
        u_l4 (.clk(clk), .rst(rst), .bus(if4.slave));

    // Raise a request mid-cycle, count cycles with stall high, sample the RESP cycle.
    task automatic access(input logic w, input logic [3:0] b, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] qo,
                          output logic eo, output int ns);
        @(negedge clk);
        cen_t = 1'b1; wen_t = w; be_t = b; a_t = addr; d_t = data;
        #1;
        ns = 0;
        while (stall_o && ns < 40) begin
            ns++;
            @(negedge clk);
        end
        qo = q_o; eo = err_o;
        cen_t = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] q; logic e; int ns;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_o); end
        total++; if (q_o !== 32'h0) begin bad++; $display("FAIL reset_q got=%h want=0", q_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err_o); end
        access(1'b0, 4'h0, BASE + 32'd4, 32'h0, q, e, ns);
        total++; if (q !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_mem got=%h/%0b want=0/0", q, e); end
    endtask

    task automatic test_write_read();
        logic [31:0] q; logic e; int ns;
        access(1'b1, 4'hF, BASE + 32'd8, 32'hDEADBEEF, q, e, ns);
        total++; if (ns != 2 || e !== 1'b0) begin bad++; $display("FAIL wr_stall got=%0d/%0b want=2/0", ns, e); end
        access(1'b0, 4'h0, BASE + 32'd8, 32'h0, q, e, ns);
        total++; if (ns != 2) begin bad++; $display("FAIL rd_stall got=%0d want=2", ns); end
        total++; if (q !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%0b want=deadbeef/0", q, e); end
        @(negedge clk);
        total++; if (q_o !== 32'h0 || err_o !== 1'b0) begin bad++; $display("FAIL idle_out got=%h/%0b want=0/0", q_o, err_o); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] q; logic e; int ns;
        access(1'b1, 4'hF, BASE + 32'd12, 32'h11223344, q, e, ns);
        access(1'b1, 4'b0101, BASE + 32'd12, 32'hAABBCCDD, q, e, ns);
        access(1'b0, 4'h0, BASE + 32'd12, 32'h0, q, e, ns);
        total++; if (q !== 32'h11BB33DD) begin bad++; $display("FAIL byte_lanes got=%h want=11bb33dd", q); end
        access(1'b1, 4'h0, BASE + 32'd12, 32'hFFFFFFFF, q, e, ns);
        total++; if (e !== 1'b0 || ns != 2) begin bad++; $display("FAIL be0_resp got=%0b/%0d want=0/2", e, ns); end
        access(1'b0, 4'h0, BASE + 32'd12, 32'h0, q, e, ns);
        total++; if (q !== 32'h11BB33DD) begin bad++; $display("FAIL be0_nochange got=%h want=11bb33dd", q); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] q; logic e; int ns;
        access(1'b0, 4'h0, BASE + 32'd128, 32'h0, q, e, ns);
        total++; if (q !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL rd_past_end got=%h/%0b want=0/1", q, e); end
        access(1'b0, 4'h0, BASE + 32'd2, 32'h0, q, e, ns);
        total++; if (q !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL rd_unaligned got=%h/%0b want=0/1", q, e); end
        access(1'b0, 4'h0, BASE - 32'd4, 32'h0, q, e, ns);
        total++; if (q !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL rd_below_base got=%h/%0b want=0/1", q, e); end
        access(1'b1, 4'hF, BASE + 32'd128, 32'hFFFFFFFF, q, e, ns);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL wr_past_end got=%0b want=1", e); end
        access(1'b1, 4'hF, BASE + 32'd2, 32'hFFFFFFFF, q, e, ns);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL wr_unaligned got=%0b want=1", e); end
        access(1'b0, 4'h0, BASE, 32'h0, q, e, ns);
        total++; if (q !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL miss_word0 got=%h/%0b want=0/0", q, e); end
        access(1'b0, 4'h0, BASE + 32'd8, 32'h0, q, e, ns);
        total++; if (q !== 32'hDEADBEEF) begin bad++; $display("FAIL miss_word2 got=%h want=deadbeef", q); end
        access(1'b1, 4'hF, BASE + 32'd124, 32'h5A5AA5A5, q, e, ns);
        access(1'b0, 4'h0, BASE + 32'd124, 32'h0, q, e, ns);
        total++; if (q !== 32'h5A5AA5A5 || e !== 1'b0) begin bad++; $display("FAIL last_word got=%h/%0b want=5a5aa5a5/0", q, e); end
    endtask

    task automatic test_latency();
        logic [31:0] q; logic e; int ns;
        sel = 2'd1;
        access(1'b1, 4'hF, BASE + 32'd20, 32'h0000BEEF, q, e, ns);
        total++; if (ns != 1) begin bad++; $display("FAIL lat1_wr got=%0d want=1", ns); end
        access(1'b0, 4'h0, BASE + 32'd20, 32'h0, q, e, ns);
        total++; if (ns != 1 || q !== 32'h0000BEEF) begin bad++; $display("FAIL lat1_rd got=%0d/%h want=1/0000beef", ns, q); end
        sel = 2'd2;
        access(1'b1, 4'hF, BASE + 32'd20, 32'h4444AAAA, q, e, ns);
        total++; if (ns != 4) begin bad++; $display("FAIL lat4_wr got=%0d want=4", ns); end
        access(1'b0, 4'h0, BASE + 32'd20, 32'h0, q, e, ns);
        total++; if (ns != 4 || q !== 32'h4444AAAA) begin bad++; $display("FAIL lat4_rd got=%0d/%h want=4/4444aaaa", ns, q); end
        @(negedge clk);
        total++; if (q_o !== 32'h0) begin bad++; $display("FAIL lat4_resp_len got=%h want=0", q_o); end
        sel = 2'd0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] q; logic e; int ns;
        @(negedge clk);
        cen_t = 1'b1; wen_t = 1'b1; be_t = 4'hF; a_t = BASE; d_t = 32'hCAFEF00D;
        @(negedge clk);
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL mid_wait_stall got=%0b want=1", stall_o); end
        rst = 1'b1;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL mid_rst_stall got=%0b want=0", stall_o); end
        cen_t = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 4'h0, BASE, 32'h0, q, e, ns);
        total++; if (q !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL mid_rst_discard got=%h/%0b want=0/0", q, e); end
        access(1'b0, 4'h0, BASE + 32'd8, 32'h0, q, e, ns);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL mid_rst_clear got=%h want=0", q); end
    endtask

    task automatic test_latched_inputs();
        logic [31:0] q; logic e; int ns;
        @(negedge clk);
        cen_t = 1'b1; wen_t = 1'b1; be_t = 4'hF; a_t = BASE + 32'd16; d_t = 32'h12345678;
        @(negedge clk);
        wen_t = 1'b0; a_t = BASE + 32'd20; d_t = 32'hFFFFFFFF; be_t = 4'h0;
        @(negedge clk);
        total++; if (stall_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL latch_wr_resp got=%0b/%0b want=0/0", stall_o, err_o); end
        cen_t = 1'b0;
        access(1'b0, 4'h0, BASE + 32'd16, 32'h0, q, e, ns);
        total++; if (q !== 32'h12345678) begin bad++; $display("FAIL latch_wr_data got=%h want=12345678", q); end
        access(1'b0, 4'h0, BASE + 32'd20, 32'h0, q, e, ns);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL latch_wr_addr got=%h want=0", q); end
        @(negedge clk);
        cen_t = 1'b1; wen_t = 1'b0; be_t = 4'h0; a_t = BASE + 32'd16; d_t = 32'h0;
        @(negedge clk);
        wen_t = 1'b1; be_t = 4'hF; a_t = BASE + 32'd200; d_t = 32'h0BADF00D;
        @(negedge clk);
        total++; if (q_o !== 32'h12345678 || err_o !== 1'b0) begin bad++; $display("FAIL latch_rd got=%h/%0b want=12345678/0", q_o, err_o); end
        cen_t = 1'b0;
        access(1'b0, 4'h0, BASE + 32'd16, 32'h0, q, e, ns);
        total++; if (q !== 32'h12345678) begin bad++; $display("FAIL latch_rd_nowrite got=%h want=12345678", q); end
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_latency();
        test_reset_mid();
        test_latched_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Reset release happens inside test_reset's caller window.
    initial begin
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    end
endmodule
